// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use hazard bubble insertion and flush/stall control.
// Optional bubble statistics counter enabled by defining ID_EX_BUBBLE_CNT_EN.
module id_ex_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_id_valid,
  input  logic [XLEN-1:0]  i_id_pc,
  input  logic [4:0]       i_id_rs1,
  input  logic [4:0]       i_id_rs2,
  input  logic             i_id_uses_rs1,
  input  logic             i_id_uses_rs2,
  input  logic [4:0]       i_id_rd,
  input  logic             i_id_r_we,
  input  logic             i_id_mem_re,
  input  logic [XLEN-1:0]  i_id_rs1_data,
  input  logic [XLEN-1:0]  i_id_rs2_data,
  input  logic [XLEN-1:0]  i_id_imm,
  input  logic             i_flush,
  input  logic             i_ex_stall,
  output logic             o_ex_valid,
  output logic [XLEN-1:0]  o_ex_pc,
  output logic [4:0]       o_ex_rs1,
  output logic [4:0]       o_ex_rs2,
  output logic [4:0]       o_ex_rd,
  output logic             o_ex_r_we,
  output logic             o_ex_mem_re,
  output logic [XLEN-1:0]  o_ex_rs1_data,
  output logic [XLEN-1:0]  o_ex_rs2_data,
  output logic [XLEN-1:0]  o_ex_imm,
  output logic             o_id_stall,
  output logic [CNT_W-1:0] o_bubble_cnt
);
  logic hazard;
  logic load_bubble;
  logic capture;
  // Load-use detection: a load in EX whose rd is read by the valid ID instruction.
  always_comb begin
    hazard = o_ex_valid && o_ex_mem_re && i_id_valid && (o_ex_rd != 5'd0) &&
             ((i_id_uses_rs1 && (i_id_rs1 == o_ex_rd)) || (i_id_uses_rs2 && (i_id_rs2 == o_ex_rd)));
    load_bubble = !i_flush && !i_ex_stall && hazard;
    capture = !i_flush && !i_ex_stall && !hazard;
    o_id_stall = i_rst_n && !i_flush && (i_ex_stall || hazard);
  end
  // EX register: reset > flush > hold > hazard bubble > capture.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_flush || load_bubble) begin
      o_ex_valid    <= 1'b0;
      o_ex_pc       <= '0;
      o_ex_rs1      <= '0;
      o_ex_rs2      <= '0;
      o_ex_rd       <= '0;
      o_ex_r_we     <= 1'b0;
      o_ex_mem_re   <= 1'b0;
      o_ex_rs1_data <= '0;
      o_ex_rs2_data <= '0;
      o_ex_imm      <= '0;
    end else if (capture) begin
      o_ex_valid    <= i_id_valid;
      o_ex_pc       <= i_id_pc;
      o_ex_rs1      <= i_id_rs1;
      o_ex_rs2      <= i_id_rs2;
      o_ex_rd       <= i_id_rd;
      o_ex_r_we     <= i_id_r_we && i_id_valid && (i_id_rd != 5'd0);
      o_ex_mem_re   <= i_id_mem_re && i_id_valid;
      o_ex_rs1_data <= i_id_rs1_data;
      o_ex_rs2_data <= i_id_rs2_data;
      o_ex_imm      <= i_id_imm;
    end
  end
`ifdef ID_EX_BUBBLE_CNT_EN
  // Saturating count of hazard bubbles; flush and stall cycles are excluded.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n)
      o_bubble_cnt <= '0;
    else if (load_bubble && (o_bubble_cnt != {CNT_W{1'b1}}))
      o_bubble_cnt <= o_bubble_cnt + CNT_W'(1);
  end
`else
  assign o_bubble_cnt = '0;
`endif
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: table-driven check of id_ex_stage plus reset and bubble-counter sequences.
module tb_id_ex_stage;
  localparam int XLEN  = 32;
  localparam int CNT_W = 2;
  logic             clk = 1'b0;
  logic             rst_n, id_valid, uses_rs1, uses_rs2, r_we, mem_re, flush, ex_stall;
  logic [XLEN-1:0]  pc, rs1_data, rs2_data, imm;
  logic [4:0]       rs1, rs2, rd;
  logic             ex_valid, ex_r_we, ex_mem_re, id_stall;
  logic [XLEN-1:0]  ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]       ex_rs1, ex_rs2, ex_rd;
  logic [CNT_W-1:0] bubble_cnt;
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_id_valid(id_valid), .i_id_pc(pc),
    .i_id_rs1(rs1), .i_id_rs2(rs2), .i_id_uses_rs1(uses_rs1), .i_id_uses_rs2(uses_rs2),
    .i_id_rd(rd), .i_id_r_we(r_we), .i_id_mem_re(mem_re),
    .i_id_rs1_data(rs1_data), .i_id_rs2_data(rs2_data), .i_id_imm(imm),
    .i_flush(flush), .i_ex_stall(ex_stall),
    .o_ex_valid(ex_valid), .o_ex_pc(ex_pc), .o_ex_rs1(ex_rs1), .o_ex_rs2(ex_rs2),
    .o_ex_rd(ex_rd), .o_ex_r_we(ex_r_we), .o_ex_mem_re(ex_mem_re),
    .o_ex_rs1_data(ex_rs1_data), .o_ex_rs2_data(ex_rs2_data), .o_ex_imm(ex_imm),
    .o_id_stall(id_stall), .o_bubble_cnt(bubble_cnt)
  );

  typedef struct {
    logic        rst_n, valid, u1, u2, we, re, flush, stall;
    logic [31:0] pc;
    logic [4:0]  rs1, rs2, rd;
    logic        e_stall, e_valid, e_we, e_re;
    logic [31:0] e_pc;
    logic [4:0]  e_rs1, e_rs2, e_rd;
    int          e_cnt;
  } vec_t;

  function automatic vec_t mk(logic rn, logic v, logic [31:0] p, logic [4:0] a, logic u1, logic [4:0] b, logic u2,
                              logic [4:0] d, logic we, logic re, logic fl, logic st,
                              logic es, logic ev, logic [31:0] ep, logic [4:0] ea, logic [4:0] eb,
                              logic [4:0] ed, logic ew, logic er, int ec);
    vec_t t;
    t.rst_n = rn; t.valid = v; t.pc = p; t.rs1 = a; t.u1 = u1; t.rs2 = b; t.u2 = u2;
    t.rd = d; t.we = we; t.re = re; t.flush = fl; t.stall = st;
    t.e_stall = es; t.e_valid = ev; t.e_pc = ep; t.e_rs1 = ea; t.e_rs2 = eb;
    t.e_rd = ed; t.e_we = ew; t.e_re = er; t.e_cnt = ec;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    rst_n = v.rst_n; id_valid = v.valid; pc = v.pc; rs1 = v.rs1; rs2 = v.rs2;
    uses_rs1 = v.u1; uses_rs2 = v.u2; rd = v.rd; r_we = v.we; mem_re = v.re;
    flush = v.flush; ex_stall = v.stall;
    rs1_data = v.pc + 32'h1000; rs2_data = v.pc + 32'h2000; imm = v.pc + 32'h3000;
  endtask

  function automatic int exp_cnt(input int c);
`ifdef ID_EX_BUBBLE_CNT_EN
    return c;
`else
    return 0 * c;
`endif
  endfunction

  task automatic check_ex(input string tag, input vec_t v);
    chk({tag, " valid"}, 32'(ex_valid), 32'(v.e_valid));
    chk({tag, " pc"}, ex_pc, v.e_pc);
    chk({tag, " rs1"}, 32'(ex_rs1), 32'(v.e_rs1));
    chk({tag, " rs2"}, 32'(ex_rs2), 32'(v.e_rs2));
    chk({tag, " rd"}, 32'(ex_rd), 32'(v.e_rd));
    chk({tag, " r_we"}, 32'(ex_r_we), 32'(v.e_we));
    chk({tag, " mem_re"}, 32'(ex_mem_re), 32'(v.e_re));
    chk({tag, " rs1_data"}, ex_rs1_data, v.e_pc == 0 ? 32'h0 : v.e_pc + 32'h1000);
    chk({tag, " rs2_data"}, ex_rs2_data, v.e_pc == 0 ? 32'h0 : v.e_pc + 32'h2000);
    chk({tag, " imm"}, ex_imm, v.e_pc == 0 ? 32'h0 : v.e_pc + 32'h3000);
    chk({tag, " bubble_cnt"}, 32'(bubble_cnt), 32'(exp_cnt(v.e_cnt)));
  endtask

  task automatic run(input string tag, input vec_t v);
    apply(v);
    #3;
    chk({tag, " id_stall"}, 32'(id_stall), 32'(v.e_stall));
    @(posedge clk);
    #1;
    check_ex(tag, v);
    n_vec++;
  endtask

  vec_t tbl[$];
  vec_t z;

  initial begin
    z = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    apply(z);
    @(posedge clk);
    #1;
    tbl.push_back(mk(0,1,'h100, 1,1, 2,1, 5,1,0, 0,0,  0, 0,0,     0, 0, 0,0,0, 0));
    tbl.push_back(mk(0,1,'h100, 1,1, 2,1, 5,1,0, 0,0,  0, 0,0,     0, 0, 0,0,0, 0));
    tbl.push_back(mk(1,1,'h100, 1,1, 2,1, 5,1,0, 0,0,  0, 1,'h100, 1, 2, 5,1,0, 0));
    tbl.push_back(mk(1,1,'h104, 3,1, 4,1, 7,1,1, 0,0,  0, 1,'h104, 3, 4, 7,1,1, 0));
    tbl.push_back(mk(1,1,'h108, 8,1, 7,1, 9,1,0, 0,0,  1, 0,0,     0, 0, 0,0,0, 1));
    tbl.push_back(mk(1,1,'h108, 8,1, 7,1, 9,1,0, 0,0,  0, 1,'h108, 8, 7, 9,1,0, 1));
    tbl.push_back(mk(1,1,'h10C, 1,1, 2,1, 0,1,1, 0,0,  0, 1,'h10C, 1, 2, 0,0,1, 1));
    tbl.push_back(mk(1,1,'h110, 0,1, 0,1, 0,1,0, 0,0,  0, 1,'h110, 0, 0, 0,0,0, 1));
    tbl.push_back(mk(1,1,'h200,10,1,11,1,12,1,0, 0,0,  0, 1,'h200,10,11,12,1,0, 1));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(1,1,'h204,13,1,14,1,15,1,0, 0,1, 1, 1,'h200,10,11,12,1,0, 1));
    tbl.push_back(mk(1,1,'h204,13,1,14,1,15,1,0, 0,0,  0, 1,'h204,13,14,15,1,0, 1));
    tbl.push_back(mk(1,0,'h208,16,1,17,1,16,1,1, 0,0,  0, 0,'h208,16,17,16,0,0, 1));
    tbl.push_back(mk(1,1,'h20C, 1,1, 2,1,20,1,1, 0,0,  0, 1,'h20C, 1, 2,20,1,1, 1));
    tbl.push_back(mk(1,0,'h210,20,1,20,1, 3,1,0, 0,0,  0, 0,'h210,20,20, 3,0,0, 1));
    tbl.push_back(mk(1,1,'h214, 1,1, 2,1,21,1,1, 0,0,  0, 1,'h214, 1, 2,21,1,1, 1));
    tbl.push_back(mk(1,1,'h218,21,1, 2,1,22,1,1, 1,1,  0, 0,0,     0, 0, 0,0,0, 1));
    tbl.push_back(mk(1,1,'h218,21,1, 2,1,22,1,1, 0,0,  0, 1,'h218,21, 2,22,1,1, 1));
    tbl.push_back(mk(1,1,'h21C, 3,0,22,1, 4,1,0, 0,1,  1, 1,'h218,21, 2,22,1,1, 1));
    tbl.push_back(mk(1,1,'h21C, 3,0,22,1, 4,1,0, 0,0,  1, 0,0,     0, 0, 0,0,0, 2));
    tbl.push_back(mk(1,1,'h21C, 3,0,22,1, 4,1,0, 0,0,  0, 1,'h21C, 3,22, 4,1,0, 2));
    tbl.push_back(mk(1,1,'h220, 1,1, 2,1, 9,1,1, 0,0,  0, 1,'h220, 1, 2, 9,1,1, 2));
    tbl.push_back(mk(1,1,'h224, 9,0, 9,0, 1,1,0, 0,0,  0, 1,'h224, 9, 9, 1,1,0, 2));
    foreach (tbl[i]) run($sformatf("vec%0d", i), tbl[i]);

    run("midrst", mk(0,1,'h300, 5,1, 5,1, 5,1,1, 0,0, 0, 0,0, 0,0,0,0,0, 0));
    for (int k = 1; k <= 5; k++) begin
      logic [31:0] lp;
      lp = 32'h400 + 32'(k) * 32'h10;
      run($sformatf("sat%0d_ld", k),  mk(1,1,lp, 1,1, 2,1, 5,1,1, 0,0, 0, 1,lp, 1, 2, 5,1,1, (k - 1 > 3) ? 3 : k - 1));
      run($sformatf("sat%0d_bub", k), mk(1,1,lp + 4, 5,1, 0,0, 6,1,0, 0,0, 1, 0,0, 0, 0, 0,0,0, (k > 3) ? 3 : k));
      run($sformatf("sat%0d_cap", k), mk(1,1,lp + 4, 5,1, 0,0, 6,1,0, 0,0, 0, 1,lp + 4, 5, 0, 6,1,0, (k > 3) ? 3 : k));
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
